// File: rtl/coherence_bus_arbiter.sv
// Snooping-bus arbiter for NUM_CPUS caches sharing one unified memory: round-robin request
// arbitration, BOCI broadcast/snoop, peer-or-memory data routing and a memory-timeout watchdog.
module coherence_bus_arbiter #(
  parameter int NUM_CPUS    = 4,
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 16,
  parameter int SNOOP_LAT   = 1,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CPUS-1:0]      read_miss,
  input  logic [NUM_CPUS-1:0]      write_miss,
  input  logic [NUM_CPUS-1:0]      invalidate,
  input  logic [NUM_CPUS*ADDR_W-1:0] BICO,
  input  logic [NUM_CPUS-1:0]      cpu_search_found,
  input  logic [NUM_CPUS*DATA_W-1:0] send_other_proc_data,
  input  logic                     u_rdy,
  output logic [NUM_CPUS-1:0]      grant,
  output logic [NUM_CPUS-1:0]      cpu_search,
  output logic [ADDR_W-1:0]        BOCI,
  output logic [NUM_CPUS-1:0]      invalidate_from_other_cpu,
  output logic [2*NUM_CPUS-1:0]    cpu_datasel,
  output logic [NUM_CPUS-1:0]      cpu_dmem_permission,
  output logic [DATA_W-1:0]        other_proc_data,
  output logic                     bus_err
);

  localparam int PW = (NUM_CPUS > 1) ? $clog2(NUM_CPUS) : 1;
  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam int SW = $clog2(SNOOP_LAT + 1);
  localparam logic [TW-1:0] TMAX       = TW'(MEM_TIMEOUT);
  localparam logic [SW-1:0] SNOOP_LAST = SW'(SNOOP_LAT - 1);

  typedef enum logic [1:0] {IDLE, SNOOP, MEM, GRANT} state_t;
  typedef enum logic [1:0] {OP_RD, OP_WR, OP_INV} op_t;

  state_t            state;
  op_t               op_q;
  op_t               arb_op;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     w_q;
  logic [PW-1:0]     arb_w;
  logic [PW-1:0]     peer_p;
  logic              arb_found;
  logic [SW-1:0]     snoop_cnt;
  logic [TW-1:0]     timer;
  logic [NUM_CPUS-1:0] req;
  logic [NUM_CPUS-1:0] win_oh;
  logic [NUM_CPUS-1:0] found_f;

  function automatic logic [NUM_CPUS-1:0] onehot(input logic [PW-1:0] i);
    onehot = '0;
    for (int k = 0; k < NUM_CPUS; k++)
      if (PW'(k) == i) onehot[k] = 1'b1;
  endfunction

  function automatic logic [2*NUM_CPUS-1:0] sel_vec(input logic [PW-1:0] i, input logic [1:0] code);
    sel_vec = '0;
    for (int k = 0; k < NUM_CPUS; k++)
      if (PW'(k) == i) sel_vec[2*k +: 2] = code;
  endfunction

  assign req     = read_miss | write_miss | invalidate;
  assign win_oh  = onehot(w_q);
  assign found_f = cpu_search_found & ~win_oh;

  // Round-robin: first requester strictly after the last winner, wrapping.
  always_comb begin
    arb_found = 1'b0;
    arb_w     = '0;
    for (int k = 1; k <= NUM_CPUS; k++) begin
      if (!arb_found && req[(int'(rr_ptr) + k) % NUM_CPUS]) begin
        arb_found = 1'b1;
        arb_w     = PW'((int'(rr_ptr) + k) % NUM_CPUS);
      end
    end
  end

  always_comb begin
    if (write_miss[arb_w])     arb_op = OP_WR;
    else if (read_miss[arb_w]) arb_op = OP_RD;
    else                       arb_op = OP_INV;
  end

  always_comb begin
    peer_p = '0;
    for (int k = NUM_CPUS - 1; k >= 0; k--)
      if (found_f[k]) peer_p = PW'(k);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                     <= IDLE;
      op_q                      <= OP_RD;
      rr_ptr                    <= PW'(NUM_CPUS - 1);
      w_q                       <= '0;
      snoop_cnt                 <= '0;
      timer                     <= '0;
      grant                     <= '0;
      cpu_search                <= '0;
      BOCI                      <= '0;
      invalidate_from_other_cpu <= '0;
      cpu_datasel               <= '0;
      cpu_dmem_permission       <= '0;
      other_proc_data           <= '0;
      bus_err                   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          grant               <= '0;
          cpu_datasel         <= '0;
          cpu_dmem_permission <= '0;
          // Skip arbitration while a grant is showing so the granted cpu has a cycle to drop its request.
          if (arb_found && grant == '0) begin
            w_q        <= arb_w;
            op_q       <= arb_op;
            BOCI       <= BICO[int'(arb_w)*ADDR_W +: ADDR_W];
            cpu_search <= ~onehot(arb_w);
            invalidate_from_other_cpu <= (arb_op != OP_RD) ? ~onehot(arb_w) : '0;
            snoop_cnt  <= '0;
            state      <= SNOOP;
          end
        end
        SNOOP: begin
          if (snoop_cnt == SNOOP_LAST) begin
            cpu_search                <= '0;
            invalidate_from_other_cpu <= '0;
            if (op_q == OP_INV) begin
              state <= GRANT;
            end else if (|found_f) begin
              other_proc_data <= send_other_proc_data[int'(peer_p)*DATA_W +: DATA_W];
              cpu_datasel     <= sel_vec(w_q, 2'b01);
              state           <= GRANT;
            end else begin
              cpu_datasel         <= sel_vec(w_q, 2'b10);
              cpu_dmem_permission <= win_oh;
              timer               <= '0;
              state               <= MEM;
            end
          end else begin
            snoop_cnt <= snoop_cnt + 1'b1;
          end
        end
        MEM: begin
          timer <= (timer == TMAX) ? timer : timer + 1'b1;
          if (u_rdy) begin
            state <= GRANT;
          end else if (timer == TMAX) begin
            bus_err <= 1'b1;
            state   <= GRANT;
          end
        end
        GRANT: begin
          grant  <= win_oh;
          rr_ptr <= w_q;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Directed bench for coherence_bus_arbiter: arbitration order, snoop strobes, peer/memory routing,
// timeout and asynchronous reset abort.
module tb_coherence_bus_arbiter;

  localparam int N  = 4;
  localparam int AW = 13;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      read_miss, write_miss, invalidate, cpu_search_found;
  logic [N*AW-1:0]   BICO;
  logic [N*DW-1:0]   send_other_proc_data;
  logic              u_rdy;
  logic [N-1:0]      grant, cpu_search, invalidate_from_other_cpu, cpu_dmem_permission;
  logic [AW-1:0]     BOCI;
  logic [2*N-1:0]    cpu_datasel;
  logic [DW-1:0]     other_proc_data;
  logic              bus_err;

  int n_checks = 0;
  int n_fail   = 0;

  coherence_bus_arbiter #(
    .NUM_CPUS(N), .ADDR_W(AW), .DATA_W(DW), .SNOOP_LAT(1), .MEM_TIMEOUT(255)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .read_miss(read_miss), .write_miss(write_miss), .invalidate(invalidate),
    .BICO(BICO), .cpu_search_found(cpu_search_found),
    .send_other_proc_data(send_other_proc_data), .u_rdy(u_rdy),
    .grant(grant), .cpu_search(cpu_search), .BOCI(BOCI),
    .invalidate_from_other_cpu(invalidate_from_other_cpu),
    .cpu_datasel(cpu_datasel), .cpu_dmem_permission(cpu_dmem_permission),
    .other_proc_data(other_proc_data), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_grant(input string tag, input logic [N-1:0] exp, input int bound);
    int c;
    c = 0;
    while (grant == '0 && c < bound) begin
      @(negedge clk);
      c++;
    end
    chk(tag, 32'(grant), 32'(exp));
  endtask

  task automatic clear_inputs();
    read_miss = '0; write_miss = '0; invalidate = '0; cpu_search_found = '0;
    BICO = '0; send_other_proc_data = '0; u_rdy = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  initial begin
    int c;
    clear_inputs();
    cyc(2);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_search", 32'(cpu_search), 0);
    chk("rst_datasel", 32'(cpu_datasel), 0);
    chk("rst_perm", 32'(cpu_dmem_permission), 0);
    chk("rst_bus_err", 32'(bus_err), 0);
    chk("rst_boci", 32'(BOCI), 0);
    rst_n = 1'b1;
    cyc(1);

    // 1: read miss, memory path
    read_miss[2] = 1'b1;
    BICO[2*AW +: AW] = 13'h0A5;
    cyc(1);
    chk("t1_boci", 32'(BOCI), 32'h0A5);
    chk("t1_search", 32'(cpu_search), 32'b1011);
    chk("t1_inv_none", 32'(invalidate_from_other_cpu), 0);
    cyc(1);
    chk("t1_perm", 32'(cpu_dmem_permission), 32'b0100);
    chk("t1_sel_mem", 32'(cpu_datasel), 32'h20);
    chk("t1_search_off", 32'(cpu_search), 0);
    cyc(2);
    u_rdy = 1'b1;
    cyc(1);
    u_rdy = 1'b0;
    chk("t1_no_grant_yet", 32'(grant), 0);
    cyc(1);
    chk("t1_grant", 32'(grant), 32'b0100);
    chk("t1_sel_at_grant", 32'(cpu_datasel), 32'h20);
    read_miss = '0;
    cyc(1);
    chk("t1_grant_clr", 32'(grant), 0);
    chk("t1_sel_clr", 32'(cpu_datasel), 0);
    chk("t1_perm_clr", 32'(cpu_dmem_permission), 0);

    // 2: simultaneous requests and round-robin rotation
    do_reset();
    u_rdy = 1'b1;
    read_miss = 4'b1001;
    wait_grant("t2_first_cpu0", 4'b0001, 20);
    read_miss[0] = 1'b0;
    read_miss[1] = 1'b1;
    cyc(1);
    read_miss[0] = 1'b1;
    wait_grant("t2_rr_cpu1", 4'b0010, 20);
    read_miss[1] = 1'b0;
    cyc(1);
    wait_grant("t2_rr_cpu3", 4'b1000, 20);
    read_miss[3] = 1'b0;
    cyc(1);
    wait_grant("t2_rr_cpu0", 4'b0001, 20);
    read_miss = '0;
    u_rdy = 1'b0;
    cyc(2);

    // 3: write miss served from a peer, lowest hitting peer wins
    write_miss[1] = 1'b1;
    BICO[1*AW +: AW] = 13'h1F0;
    cpu_search_found = 4'b1001;
    send_other_proc_data[0*DW +: DW] = 16'h1234;
    send_other_proc_data[1*DW +: DW] = 16'h5555;
    send_other_proc_data[3*DW +: DW] = 16'hBEEF;
    cyc(1);
    chk("t3_boci", 32'(BOCI), 32'h1F0);
    chk("t3_inv", 32'(invalidate_from_other_cpu), 32'b1101);
    chk("t3_search", 32'(cpu_search), 32'b1101);
    cyc(1);
    chk("t3_no_grant_yet", 32'(grant), 0);
    chk("t3_data", 32'(other_proc_data), 32'h1234);
    chk("t3_sel_peer", 32'(cpu_datasel), 32'h04);
    chk("t3_inv_off", 32'(invalidate_from_other_cpu), 0);
    chk("t3_perm_none", 32'(cpu_dmem_permission), 0);
    cyc(1);
    chk("t3_grant_cycle3", 32'(grant), 32'b0010);
    write_miss = '0;
    cpu_search_found = '0;
    cyc(1);
    chk("t3_sel_clr", 32'(cpu_datasel), 0);
    cyc(1);

    // 4: invalidate-only upgrade, hits are irrelevant
    invalidate[3] = 1'b1;
    cpu_search_found = 4'b0001;
    cyc(1);
    chk("t4_inv", 32'(invalidate_from_other_cpu), 32'b0111);
    chk("t4_search", 32'(cpu_search), 32'b0111);
    cyc(1);
    chk("t4_inv_off", 32'(invalidate_from_other_cpu), 0);
    chk("t4_perm_none", 32'(cpu_dmem_permission), 0);
    cyc(1);
    chk("t4_grant", 32'(grant), 32'b1000);
    chk("t4_perm_still0", 32'(cpu_dmem_permission), 0);
    chk("t4_sel_none", 32'(cpu_datasel), 0);
    invalidate = '0;
    cpu_search_found = '0;
    cyc(2);

    // 5: memory never answers
    read_miss[0] = 1'b1;
    cyc(2);
    chk("t5_perm", 32'(cpu_dmem_permission), 32'b0001);
    cyc(250);
    chk("t5_err_not_yet", 32'(bus_err), 0);
    chk("t5_no_early_grant", 32'(grant), 0);
    c = 0;
    while (!bus_err && c < 20) begin
      cyc(1);
      c++;
    end
    chk("t5_bus_err", 32'(bus_err), 1);
    chk("t5_grant_after_err", 32'(grant), 0);
    wait_grant("t5_grant", 4'b0001, 5);
    read_miss = '0;
    cyc(3);
    chk("t5_err_sticky", 32'(bus_err), 1);

    // 6: asynchronous reset in the middle of a memory access
    read_miss[2] = 1'b1;
    cyc(3);
    chk("t6_in_mem", 32'(cpu_dmem_permission), 32'b0100);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_grant0", 32'(grant), 0);
    chk("t6_sel0", 32'(cpu_datasel), 0);
    chk("t6_perm0", 32'(cpu_dmem_permission), 0);
    chk("t6_err0", 32'(bus_err), 0);
    read_miss = '0;
    cyc(1);
    rst_n = 1'b1;
    read_miss = 4'b1010;
    u_rdy = 1'b1;
    wait_grant("t6_after_reset", 4'b0010, 20);
    read_miss = '0;
    u_rdy = 1'b0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
